// File: rtl/cpu_clock_pkg.sv
// Shared types and constants for the CPU clock-enable sequencer.
package cpu_clock_pkg;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_BURST  = 2'b11
  } cc_state_t;

  // Speed switch codes; 01 is an unused code that falls back to slow.
  localparam logic [1:0] SPEED_SLOW     = 2'b00;
  localparam logic [1:0] SPEED_SLOW_ALT = 2'b01;
  localparam logic [1:0] SPEED_FAST     = 2'b10;
  localparam logic [1:0] SPEED_FASTEST  = 2'b11;

  // Board defaults for a 50 MHz-class source clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_DIV_SLOW        = 25000000;
  localparam int unsigned DEF_DIV_FAST        = 2000000;
  localparam int unsigned DEF_DIV_FASTEST     = 100000;

  // Cycles per tick for the current speed switch setting.
  function automatic logic [31:0] select_div(input logic [1:0] speed,
                                             input logic [31:0] d_slow,
                                             input logic [31:0] d_fast,
                                             input logic [31:0] d_fastest);
    case (speed)
      SPEED_FASTEST:  return d_fastest;
      SPEED_FAST:     return d_fast;
      SPEED_SLOW,
      SPEED_SLOW_ALT: return d_slow;
      default:        return d_slow;
    endcase
  endfunction

endpackage

// File: rtl/cpu_clock_controller_step_debouncer.sv
// Push-button conditioner: 2-flop synchronizer plus stability counter.
// After reset the button must be seen released for a full debounce window
// before any press is accepted, so a button held through reset never
// produces a rising edge on db.
module step_debouncer
  import cpu_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic source_clock,
  input  logic reset_n,
  input  logic raw,
  output logic db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the source_clock domain.
  always_ff @(posedge source_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Arm on a stable release, then accept a level only after it holds for the full window.
  always_ff @(posedge source_clock or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
    end else if (!armed) begin
      if (sync1 || sync2) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        armed <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (sync2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      db  <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// CPU clock-enable sequencer: free-run at a selectable rate, single-step on
// a debounced button, fixed-length bursts, and halt on breakpoint request.
// cpu_tick is a one-cycle enable, not a derived clock.
module cpu_clock_controller
  import cpu_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DIV_SLOW        = DEF_DIV_SLOW,
  parameter int unsigned DIV_FAST        = DEF_DIV_FAST,
  parameter int unsigned DIV_FASTEST     = DEF_DIV_FASTEST
) (
  input  logic        source_clock,
  input  logic        reset_n,
  input  logic        step,
  input  logic        run,
  input  logic [1:0]  speed,
  input  logic [15:0] burst_count,
  input  logic        burst_start,
  input  logic        halt_req,
  output logic        cpu_tick,
  output logic [1:0]  state,
  output logic        busy,
  output logic [31:0] tick_count
);

  cc_state_t   state_q;
  cc_state_t   state_d;
  logic        db;
  logic        db_q;
  logic        step_rise;
  logic [31:0] div;
  logic [31:0] div_cnt;
  logic [31:0] div_cnt_d;
  logic        tick_due;
  logic        tick_d;
  logic [15:0] remaining;
  logic [15:0] remaining_d;
  logic        busy_d;
  logic [31:0] tick_count_q;

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .source_clock(source_clock),
    .reset_n     (reset_n),
    .raw         (step),
    .db          (db)
  );

  assign step_rise = db & ~db_q;
  assign div       = select_div(speed, 32'(DIV_SLOW), 32'(DIV_FAST), 32'(DIV_FASTEST));
  // >= rather than == so a speed change to a shorter period never overshoots.
  assign tick_due  = (div_cnt >= (div - 32'd1));

  // Next state, tick decision, divider and burst bookkeeping.
  always_comb begin
    state_d     = state_q;
    tick_d      = 1'b0;
    div_cnt_d   = div_cnt;
    remaining_d = remaining;
    case (state_q)
      ST_HALTED: begin
        if (step_rise) begin
          state_d = ST_STEP;
          tick_d  = 1'b1;
        end else if (burst_start && (burst_count != 16'd0) && !halt_req) begin
          state_d     = ST_BURST;
          remaining_d = burst_count;
          div_cnt_d   = '0;
        end else if (run && !halt_req) begin
          state_d   = ST_RUN;
          div_cnt_d = '0;
        end
      end
      ST_STEP: begin
        if (!db) state_d = ST_HALTED;
      end
      ST_RUN: begin
        if (halt_req || !run) begin
          state_d = ST_HALTED;
        end else if (tick_due) begin
          tick_d    = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt + 32'd1;
        end
      end
      ST_BURST: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (tick_due) begin
          tick_d      = 1'b1;
          div_cnt_d   = '0;
          remaining_d = remaining - 16'd1;
          if (remaining == 16'd1) state_d = ST_HALTED;
        end else begin
          div_cnt_d = div_cnt + 32'd1;
        end
      end
      default: state_d = ST_HALTED;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_BURST);
  end

  // Sequencer registers; every output is taken straight from a flop.
  always_ff @(posedge source_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HALTED;
      db_q         <= 1'b0;
      div_cnt      <= '0;
      remaining    <= '0;
      cpu_tick     <= 1'b0;
      busy         <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q   <= state_d;
      db_q      <= db;
      div_cnt   <= div_cnt_d;
      remaining <= remaining_d;
      cpu_tick  <= tick_d;
      busy      <= busy_d;
      if (tick_d) tick_count_q <= tick_count_q + 32'd1;
    end
  end

  assign state      = state_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Scenario bench for cpu_clock_controller with small dividers and debounce.
module tb_cpu_clock_controller;

  localparam int DB  = 4;
  localparam int DS  = 8;
  localparam int DF  = 4;
  localparam int DFF = 2;
  // Edges from driving a press to the tick: 2 sync + debounce + 1.
  localparam int STEP_LAT = 2 + DB + 1;
  localparam logic [1:0] S_HALTED = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_STEP   = 2'b10;
  localparam logic [1:0] S_BURST  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  speed = 2'b00;
  logic [15:0] burst_count = 16'd0;
  logic        burst_start = 1'b0;
  logic        halt_req = 1'b0;
  logic        cpu_tick;
  logic [1:0]  state;
  logic        busy;
  logic [31:0] tick_count;

  int total = 0;
  int bad = 0;
  int exp_tc = 0;

  always #5 clk = ~clk;

  cpu_clock_controller #(
    .DEBOUNCE_CYCLES(DB),
    .DIV_SLOW       (DS),
    .DIV_FAST       (DF),
    .DIV_FASTEST    (DFF)
  ) dut (
    .source_clock(clk),
    .reset_n     (rst_n),
    .step        (step),
    .run         (run),
    .speed       (speed),
    .burst_count (burst_count),
    .burst_start (burst_start),
    .halt_req    (halt_req),
    .cpu_tick    (cpu_tick),
    .state       (state),
    .busy        (busy),
    .tick_count  (tick_count)
  );

  function automatic int div_of(input logic [1:0] sp);
    case (sp)
      2'b11:   return DFF;
      2'b10:   return DF;
      default: return DS;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    total++; if (cpu_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b exp=0", cpu_tick); end
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (tick_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", tick_count); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_tc = 0;
    idle(10);
  endtask

  task automatic test_run();
    int nt;
    int d2;
    int m;
    logic e;
    nt = $urandom_range(3, 10);
    speed = 2'b11;
    run = 1'b1;
    cyc();
    total++; if (state !== S_RUN) begin bad++; $display("FAIL run_enter state got=%0d exp=1", state); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_enter busy got=%0b exp=1", busy); end
    for (int k = 1; k <= 2 * nt; k++) begin
      cyc();
      e = (k % 2 == 0);
      if (e) exp_tc++;
      total++; if (cpu_tick !== e) begin bad++; $display("FAIL run_fastest k=%0d got=%0b exp=%0b", k, cpu_tick, e); end
    end
    total++; if (tick_count !== 32'(exp_tc)) begin bad++; $display("FAIL run_count got=%0d exp=%0d", tick_count, exp_tc); end
    speed = 2'($urandom_range(0, 2));
    d2 = div_of(speed);
    for (int k = 1; k <= 3 * d2; k++) begin
      cyc();
      e = (k % d2 == 0);
      if (e) exp_tc++;
      total++; if (cpu_tick !== e) begin bad++; $display("FAIL run_respeed sp=%0d k=%0d got=%0b exp=%0b", speed, k, cpu_tick, e); end
    end
    m = $urandom_range(1, d2 - 2);
    for (int k = 1; k <= m; k++) begin
      cyc();
      total++; if (cpu_tick !== 1'b0) begin bad++; $display("FAIL run_pre_lower k=%0d got=%0b exp=0", k, cpu_tick); end
    end
    speed = 2'b11;
    cyc();
    exp_tc++;
    total++; if (cpu_tick !== 1'b1) begin bad++; $display("FAIL run_lower_div got=%0b exp=1", cpu_tick); end
    run = 1'b0;
    cyc();
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL run_stop state got=%0d exp=0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL run_stop busy got=%0b exp=0", busy); end
    total++; if (cpu_tick !== 1'b0) begin bad++; $display("FAIL run_stop tick got=%0b exp=0", cpu_tick); end
    total++; if (tick_count !== 32'(exp_tc)) begin bad++; $display("FAIL run_end_count got=%0d exp=%0d", tick_count, exp_tc); end
    idle(3);
  endtask

  task automatic test_step();
    int hold;
    int nticks;
    logic e;
    nticks = 0;
    step = 1'b1;
    idle(2);
    step = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (cpu_tick === 1'b1) nticks++;
    end
    total++; if (nticks != 0) begin bad++; $display("FAIL step_bounce ticks got=%0d exp=0", nticks); end
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL step_bounce state got=%0d exp=0", state); end
    hold = $urandom_range(12, 25);
    step = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      cyc();
      e = (k == STEP_LAT);
      total++; if (cpu_tick !== e) begin bad++; $display("FAIL step_hold k=%0d got=%0b exp=%0b", k, cpu_tick, e); end
      if (k == STEP_LAT - 1) begin
        total++; if (state !== S_HALTED) begin bad++; $display("FAIL step_pre state got=%0d exp=0", state); end
      end
    end
    exp_tc++;
    total++; if (state !== S_STEP) begin bad++; $display("FAIL step_held state got=%0d exp=2", state); end
    step = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      cyc();
      total++; if (cpu_tick !== 1'b0) begin bad++; $display("FAIL step_release r=%0d got=%0b exp=0", r, cpu_tick); end
      if (r == 4) begin
        total++; if (state !== S_STEP) begin bad++; $display("FAIL step_release_early state got=%0d exp=2", state); end
      end
      if (r == STEP_LAT) begin
        total++; if (state !== S_HALTED) begin bad++; $display("FAIL step_release_done state got=%0d exp=0", state); end
      end
    end
    total++; if (tick_count !== 32'(exp_tc)) begin bad++; $display("FAIL step_count got=%0d exp=%0d", tick_count, exp_tc); end
  endtask

  task automatic test_burst();
    int n;
    int nticks;
    logic e;
    n = $urandom_range(1, 6);
    speed = 2'b10;
    burst_count = 16'(n);
    burst_start = 1'b1;
    cyc();
    burst_start = 1'b0;
    total++; if (state !== S_BURST) begin bad++; $display("FAIL burst_enter state got=%0d exp=3", state); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL burst_enter busy got=%0b exp=1", busy); end
    for (int k = 1; k <= 4 * n + 8; k++) begin
      cyc();
      e = (k % 4 == 0) && (k / 4 <= n);
      if (e) exp_tc++;
      total++; if (cpu_tick !== e) begin bad++; $display("FAIL burst n=%0d k=%0d got=%0b exp=%0b", n, k, cpu_tick, e); end
      if (k == 4 * n - 1) begin
        total++; if (state !== S_BURST) begin bad++; $display("FAIL burst_mid state got=%0d exp=3", state); end
      end
      if (k == 4 * n) begin
        total++; if (state !== S_HALTED) begin bad++; $display("FAIL burst_end state got=%0d exp=0", state); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_end busy got=%0b exp=0", busy); end
      end
    end
    burst_count = 16'd0;
    burst_start = 1'b1;
    cyc();
    burst_start = 1'b0;
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL burst_zero state got=%0d exp=0", state); end
    nticks = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (cpu_tick === 1'b1) nticks++;
    end
    total++; if (nticks != 0) begin bad++; $display("FAIL burst_zero ticks got=%0d exp=0", nticks); end
    total++; if (tick_count !== 32'(exp_tc)) begin bad++; $display("FAIL burst_count got=%0d exp=%0d", tick_count, exp_tc); end
  endtask

  task automatic test_halt();
    int nt;
    int nticks;
    logic e;
    nt = $urandom_range(0, 4);
    speed = 2'b11;
    run = 1'b1;
    cyc();
    for (int k = 1; k <= 2 * nt + 1; k++) begin
      cyc();
      e = (k % 2 == 0);
      if (e) exp_tc++;
      total++; if (cpu_tick !== e) begin bad++; $display("FAIL halt_prerun k=%0d got=%0b exp=%0b", k, cpu_tick, e); end
    end
    halt_req = 1'b1;
    cyc();
    total++; if (cpu_tick !== 1'b0) begin bad++; $display("FAIL halt_suppress tick got=%0b exp=0", cpu_tick); end
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL halt_suppress state got=%0d exp=0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL halt_suppress busy got=%0b exp=0", busy); end
    nticks = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (cpu_tick === 1'b1) nticks++;
    end
    total++; if (nticks != 0) begin bad++; $display("FAIL halt_hold ticks got=%0d exp=0", nticks); end
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL halt_hold state got=%0d exp=0", state); end
    step = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      e = (k == STEP_LAT);
      total++; if (cpu_tick !== e) begin bad++; $display("FAIL halt_step k=%0d got=%0b exp=%0b", k, cpu_tick, e); end
    end
    exp_tc++;
    step = 1'b0;
    nticks = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (cpu_tick === 1'b1) nticks++;
    end
    total++; if (nticks != 0) begin bad++; $display("FAIL halt_step_release ticks got=%0d exp=0", nticks); end
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL halt_step_release state got=%0d exp=0", state); end
    run = 1'b0;
    halt_req = 1'b0;
    cyc();
    total++; if (tick_count !== 32'(exp_tc)) begin bad++; $display("FAIL halt_count got=%0d exp=%0d", tick_count, exp_tc); end
  endtask

  task automatic test_reset_mid_burst();
    int nticks;
    speed = 2'b10;
    burst_count = 16'd5;
    burst_start = 1'b1;
    cyc();
    burst_start = 1'b0;
    idle(3);
    cyc();
    total++; if (cpu_tick !== 1'b1) begin bad++; $display("FAIL rstburst_first got=%0b exp=1", cpu_tick); end
    rst_n = 1'b0;
    #1;
    exp_tc = 0;
    total++; if (cpu_tick !== 1'b0) begin bad++; $display("FAIL rstburst_tick got=%0b exp=0", cpu_tick); end
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL rstburst_state got=%0d exp=0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstburst_busy got=%0b exp=0", busy); end
    total++; if (tick_count !== 32'd0) begin bad++; $display("FAIL rstburst_count got=%0d exp=0", tick_count); end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    nticks = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (cpu_tick === 1'b1) nticks++;
    end
    total++; if (nticks != 0) begin bad++; $display("FAIL rstburst_after ticks got=%0d exp=0", nticks); end
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL rstburst_after state got=%0d exp=0", state); end
  endtask

  task automatic test_step_through_reset();
    int nticks;
    logic e;
    step = 1'b1;
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    exp_tc = 0;
    nticks = 0;
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (cpu_tick === 1'b1) nticks++;
    end
    total++; if (nticks != 0) begin bad++; $display("FAIL held_reset ticks got=%0d exp=0", nticks); end
    step = 1'b0;
    idle(12);
    step = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      e = (k == STEP_LAT);
      total++; if (cpu_tick !== e) begin bad++; $display("FAIL held_repress k=%0d got=%0b exp=%0b", k, cpu_tick, e); end
    end
    exp_tc++;
    step = 1'b0;
    idle(12);
    total++; if (tick_count !== 32'(exp_tc)) begin bad++; $display("FAIL held_count got=%0d exp=%0d", tick_count, exp_tc); end
  endtask

  task automatic test_step_vs_burst();
    int nticks;
    int nbusy;
    logic e;
    speed = 2'b10;
    burst_count = 16'd4;
    step = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      e = (k == STEP_LAT);
      total++; if (cpu_tick !== e) begin bad++; $display("FAIL race_tick k=%0d got=%0b exp=%0b", k, cpu_tick, e); end
      if (k == STEP_LAT) begin
        total++; if (state !== S_STEP) begin bad++; $display("FAIL race_state got=%0d exp=2", state); end
      end
      burst_start = (k == STEP_LAT - 1);
    end
    exp_tc++;
    step = 1'b0;
    nticks = 0;
    nbusy = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (cpu_tick === 1'b1) nticks++;
      if (busy === 1'b1) nbusy++;
    end
    total++; if (nticks != 0) begin bad++; $display("FAIL race_after ticks got=%0d exp=0", nticks); end
    total++; if (nbusy != 0) begin bad++; $display("FAIL race_busy cycles got=%0d exp=0", nbusy); end
    total++; if (state !== S_HALTED) begin bad++; $display("FAIL race_end state got=%0d exp=0", state); end
    total++; if (tick_count !== 32'(exp_tc)) begin bad++; $display("FAIL race_count got=%0d exp=%0d", tick_count, exp_tc); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_burst();
    test_halt();
    test_reset_mid_burst();
    test_step_through_reset();
    test_step_vs_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
